// File: rtl/bp_dma_column_arbiter_if.sv
// Bundle of the per-column request side and the merged DMA link side of
// the column arbiter. The arbiter uses the slave view, the environment
// feeding and draining it uses the master view.
interface bp_dma_column_arbiter_if #(
    parameter int num_cols_p   = 4,
    parameter int flit_width_p = 64
);
    localparam int gnt_width_lp = (num_cols_p > 1) ? $clog2(num_cols_p) : 1;

    logic [num_cols_p-1:0]              v_i;
    logic [num_cols_p*flit_width_p-1:0] data_i;
    logic [num_cols_p-1:0]              ready_and_o;
    logic                               v_o;
    logic [flit_width_p-1:0]            data_o;
    logic                               ready_and_i;
    logic                               lock_o;
    logic [gnt_width_lp-1:0]            gnt_id_o;

    modport slave (
        input  v_i, data_i, ready_and_i,
        output ready_and_o, v_o, data_o, lock_o, gnt_id_o
    );

    modport master (
        output v_i, data_i, ready_and_i,
        input  ready_and_o, v_o, data_o, lock_o, gnt_id_o
    );
endinterface

// File: rtl/bp_dma_column_arbiter.sv
// Round-robin wormhole arbiter merging per-column DMA flit streams onto a
// single DMA link. A column owns the link from its header flit until its
// last body flit; the data path is purely combinational.
module bp_dma_column_arbiter #(
    parameter int num_cols_p   = 4,
    parameter int flit_width_p = 64,
    parameter int len_width_p  = 4,
    parameter int len_lsb_p    = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_dma_column_arbiter_if.slave  link
);
    localparam int gnt_width_lp = (num_cols_p > 1) ? $clog2(num_cols_p) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BUSY = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [gnt_width_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [gnt_width_lp-1:0] gnt_q, gnt_d;
    logic [len_width_p-1:0]  cnt_q, cnt_d;

    logic [gnt_width_lp-1:0] sel_s;
    logic [gnt_width_lp-1:0] cur_s;
    logic                    any_v_s;
    logic                    v_s;
    logic                    hs_s;
    logic [flit_width_p-1:0] data_s;
    logic [len_width_p-1:0]  len_s;

    // Column index after col, wrapping the last column back to column 0.
    function automatic logic [gnt_width_lp-1:0] next_col(input logic [gnt_width_lp-1:0] col);
        if (col >= gnt_width_lp'(num_cols_p - 1)) begin
            next_col = {gnt_width_lp{1'b0}};
        end else begin
            next_col = col + gnt_width_lp'(1);
        end
    endfunction

    // Round-robin search: first valid column starting at the priority pointer.
    always_comb begin
        logic [gnt_width_lp-1:0] scan_v;
        logic                    found_v;
        sel_s   = rr_ptr_q;
        scan_v  = rr_ptr_q;
        found_v = 1'b0;
        for (int i = 0; i < num_cols_p; i++) begin
            if (!found_v && link.v_i[scan_v]) begin
                sel_s   = scan_v;
                found_v = 1'b1;
            end else begin
                sel_s   = sel_s;
            end
            scan_v = next_col(scan_v);
        end
    end

    // Output steering: the arbitration winner in IDLE, the locked column otherwise.
    always_comb begin
        any_v_s = |link.v_i;
        if (state_q == IDLE) begin
            cur_s = sel_s;
            v_s   = any_v_s;
        end else begin
            cur_s = gnt_q;
            v_s   = link.v_i[gnt_q];
        end
        data_s           = {flit_width_p{1'b0}};
        link.ready_and_o = {num_cols_p{1'b0}};
        for (int c = 0; c < num_cols_p; c++) begin
            if (cur_s == gnt_width_lp'(c)) begin
                data_s              = link.data_i[c*flit_width_p +: flit_width_p];
                link.ready_and_o[c] = link.ready_and_i & ((state_q != IDLE) | any_v_s);
            end else begin
                link.ready_and_o[c] = 1'b0;
            end
        end
        hs_s          = v_s & link.ready_and_i;
        len_s         = data_s[len_lsb_p +: len_width_p];
        link.v_o      = v_s;
        link.data_o   = data_s;
        link.lock_o   = (state_q != IDLE);
        link.gnt_id_o = cur_s;
    end

    // Next-state logic: header length decides single-flit release or wormhole lock.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    if (len_s == {len_width_p{1'b0}}) begin
                        rr_ptr_d = next_col(sel_s);
                    end else begin
                        state_d = BUSY;
                        gnt_d   = sel_s;
                        cnt_d   = len_s;
                    end
                end else if (any_v_s) begin
                    // Header stalled by the link: freeze it so nothing can displace it.
                    state_d = WAIT;
                    gnt_d   = sel_s;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (hs_s) begin
                    if (len_s == {len_width_p{1'b0}}) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_col(gnt_q);
                    end else begin
                        state_d = BUSY;
                        cnt_d   = len_s;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            BUSY: begin
                if (hs_s) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_col(gnt_q);
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= {gnt_width_lp{1'b0}};
            gnt_q    <= {gnt_width_lp{1'b0}};
            cnt_q    <= {len_width_p{1'b0}};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule
